// File: rtl/tartaruga_pkg.sv
// Shared types and default geometry for the tartaruga data cache.
package tartaruga_pkg;

  typedef enum logic [1:0] {IDLE, WB_REQ, REFILL_REQ, REFILL_WAIT} dcache_state_t;
  typedef logic [31:0] bus32_t;

  localparam int DCACHE_NUM_SETS       = 16;
  localparam int DCACHE_NUM_WAYS       = 2;
  localparam int DCACHE_WORDS_PER_LINE = 4;

  // Index width that never collapses to zero, so single-entry dimensions still get a 1-bit select.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Victim way selection: lowest invalid way wins, otherwise the set's round-robin pointer.
module dcache_victim_sel #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    ptr_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic                any_invalid_o
);

  always_comb begin
    victim_o      = ptr_i;
    any_invalid_o = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o      = WAY_W'(w);
        any_invalid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/assoc_wb_dcache.sv
// N-way set-associative write-back / write-allocate data cache with a line-wide memory port.
// Optional DCACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module assoc_wb_dcache
  import tartaruga_pkg::*;
#(
  parameter int NUM_SETS       = DCACHE_NUM_SETS,
  parameter int NUM_WAYS       = DCACHE_NUM_WAYS,
  parameter int WORDS_PER_LINE = DCACHE_WORDS_PER_LINE
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic [31:0]                   addr_i,
  input  logic                          we_i,
  input  logic [3:0]                    be_i,
  input  logic [31:0]                   data_wr_i,
  output logic                          ready_o,
  output logic [31:0]                   data_rd_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [32*WORDS_PER_LINE-1:0]  mem_data_wr_o,
  input  logic                          mem_rsp_valid_i,
  output logic                          mem_rsp_ready_o,
  input  logic [32*WORDS_PER_LINE-1:0]  mem_data_line_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_hit_o,
  output logic [31:0]                   perf_miss_o,
  output logic [31:0]                   perf_wb_o
`endif
);

  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int OFF_W  = 2 + $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WAY_W  = clog2_min1(NUM_WAYS);
  localparam int WIDX_W = clog2_min1(WORDS_PER_LINE);

  dcache_state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_d [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]             valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][LINE_W-1:0] data_q, data_d;

  bus32_t             maddr_q, maddr_d;
  logic [WAY_W-1:0]   vic_q, vic_d;
  logic               any_inv_q, any_inv_d;

  logic               mreq_vld_q, mreq_vld_d;
  logic               mem_we_q, mem_we_d;
  bus32_t             mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               rsp_rdy_q, rsp_rdy_d;

  // Request decode
  logic [TAG_W-1:0]  req_tag, m_tag;
  logic [IDX_W-1:0]  req_idx, m_idx;
  logic [WIDX_W-1:0] req_widx;

  assign req_tag = addr_i[31 -: TAG_W];
  assign req_idx = addr_i[OFF_W +: IDX_W];
  assign m_tag   = maddr_q[31 -: TAG_W];
  assign m_idx   = maddr_q[OFF_W +: IDX_W];

  if (WORDS_PER_LINE > 1) begin : g_widx
    assign req_widx = addr_i[2 +: WIDX_W];
  end else begin : g_widx1
    assign req_widx = '0;
  end

  // Lookup; only valid ways may match
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WORDS_PER_LINE-1:0][31:0] hit_words, hit_merge;

  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit       = |hit_vec;
  assign hit_words = data_q[req_idx][hit_way];

  always_comb begin
    hit_merge = hit_words;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) hit_merge[req_widx][b*8 +: 8] = data_wr_i[b*8 +: 8];
    end
  end

  logic idle, hit_acc, miss_acc;
  assign idle     = (state_q == IDLE);
  assign hit_acc  = idle && valid_i && hit;
  assign miss_acc = idle && valid_i && !hit;

  assign ready_o   = idle && (!valid_i || hit);
  assign data_rd_o = (hit_acc && !we_i) ? hit_words[req_widx] : 32'h0;

  // Victim choice for the requested set
  logic [WAY_W-1:0] rr_ptr, victim;
  logic             any_inv;

  dcache_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_victim_sel (
    .valid_i       (valid_q[req_idx]),
    .ptr_i         (rr_ptr),
    .victim_o      (victim),
    .any_invalid_o (any_inv)
  );

  logic refill_done;
  assign refill_done = (state_q == REFILL_WAIT) && mem_rsp_valid_i;

  if (NUM_WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] rr_q [NUM_SETS];
    logic [WAY_W-1:0] rr_d [NUM_SETS];

    // Pointer only moves when a valid line was displaced, so cold fills keep it parked.
    always_comb begin
      rr_d = rr_q;
      if (refill_done && !any_inv_q) rr_d[m_idx] = rr_q[m_idx] + 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) rr_q <= '{default: '0};
      else       rr_q <= rr_d;
    end

    assign rr_ptr = rr_q[req_idx];
  end else begin : g_no_rr
    assign rr_ptr = '0;
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_d      = data_q;
    maddr_d     = maddr_q;
    vic_d       = vic_q;
    any_inv_d   = any_inv_q;
    mreq_vld_d  = mreq_vld_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdy_d   = rsp_rdy_q;
    case (state_q)
      IDLE: begin
        if (hit_acc && we_i) begin
          data_d[req_idx][hit_way]  = hit_merge;
          dirty_d[req_idx][hit_way] = 1'b1;
        end else if (miss_acc) begin
          maddr_d    = {addr_i[31:OFF_W], {OFF_W{1'b0}}};
          vic_d      = victim;
          any_inv_d  = any_inv;
          mreq_vld_d = 1'b1;
          if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
            state_d     = WB_REQ;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[req_idx][victim], req_idx, {OFF_W{1'b0}}};
            mem_wdata_d = data_q[req_idx][victim];
          end else begin
            state_d    = REFILL_REQ;
            mem_we_d   = 1'b0;
            mem_addr_d = {addr_i[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
      end
      WB_REQ: begin
        if (mem_req_ready_i) begin
          dirty_d[m_idx][vic_q] = 1'b0;
          state_d     = REFILL_REQ;
          mem_we_d    = 1'b0;
          mem_addr_d  = maddr_q;
          mem_wdata_d = '0;
        end
      end
      REFILL_REQ: begin
        if (mem_req_ready_i) begin
          state_d    = REFILL_WAIT;
          mreq_vld_d = 1'b0;
          mem_addr_d = '0;
          rsp_rdy_d  = 1'b1;
        end
      end
      REFILL_WAIT: begin
        if (mem_rsp_valid_i) begin
          data_d[m_idx][vic_q]  = mem_data_line_i;
          tag_d[m_idx][vic_q]   = m_tag;
          valid_d[m_idx][vic_q] = 1'b1;
          dirty_d[m_idx][vic_q] = 1'b0;
          rsp_rdy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      maddr_q     <= '0;
      vic_q       <= '0;
      any_inv_q   <= 1'b0;
      mreq_vld_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      maddr_q     <= maddr_d;
      vic_q       <= vic_d;
      any_inv_q   <= any_inv_d;
      mreq_vld_q  <= mreq_vld_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdy_q   <= rsp_rdy_d;
    end
  end

  // Payload arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign mem_req_valid_o = mreq_vld_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_wr_o   = mem_wdata_q;
  assign mem_rsp_ready_o = rsp_rdy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i && idle && valid_i) assert ($onehot0(hit_vec));
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d, perf_wb_q, perf_wb_d;

  always_comb begin
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    perf_wb_d   = perf_wb_q;
    if (hit_acc && (perf_hit_q != '1))   perf_hit_d  = perf_hit_q + 32'd1;
    if (miss_acc && (perf_miss_q != '1)) perf_miss_d = perf_miss_q + 32'd1;
    if ((state_q == WB_REQ) && mem_req_ready_i && (perf_wb_q != '1)) perf_wb_d = perf_wb_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
      perf_wb_q   <= '0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
      perf_wb_q   <= perf_wb_d;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
  assign perf_wb_o   = perf_wb_q;
`endif

  logic unused_ok;
  assign unused_ok = ^addr_i[1:0];

endmodule

// File: tb/tb_assoc_wb_dcache.sv
// Directed bench for assoc_wb_dcache (default geometry: 16 sets, 2 ways, 4 words/line).
module tb_assoc_wb_dcache;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0, we_i = 1'b0;
  logic [31:0]  addr_i = '0, data_wr_i = '0;
  logic [3:0]   be_i = '0;
  logic         ready_o;
  logic [31:0]  data_rd_o;
  logic         mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i, mem_rsp_ready_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_wr_o, mem_data_line_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  perf_hit_o, perf_miss_o, perf_wb_o;
`endif

  always #5 clk = ~clk;

  assoc_wb_dcache dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .data_wr_i(data_wr_i), .ready_o(ready_o), .data_rd_o(data_rd_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_ready_o(mem_rsp_ready_o), .mem_data_line_i(mem_data_line_i)
`ifdef DCACHE_PERF_CNT_EN
    , .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o), .perf_wb_o(perf_wb_o)
`endif
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory: written-back lines override the fixed pattern.
  logic [127:0] mem_store [logic [31:0]];
  function automatic logic [127:0] line_for(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    if (a == 32'h100) return {32'h44, 32'h33, 32'h22, 32'h11};
    return {32'hA000_0003 | a, 32'hA000_0002 | a, 32'hA000_0001 | a, 32'hA000_0000 | a};
  endfunction

  logic         lg_we [$];
  logic [31:0]  lg_addr [$];
  logic [127:0] lg_data [$];

  int           stall_cfg = 0;
  bit           manual_mem = 1'b0;
  int           st_cnt = 0;
  logic [31:0]  pend_addr = '0;
  logic         f_we;
  logic [31:0]  f_addr;
  logic [127:0] f_data;

  // Memory responder: accepts a request after stall_cfg refused cycles and checks it holds meanwhile.
  initial begin
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_data_line_i = '0;
    forever begin
      @(negedge clk); #2;
      if (!manual_mem) begin
        mem_rsp_valid_i = mem_rsp_ready_o;
        mem_data_line_i = mem_rsp_ready_o ? line_for(pend_addr) : '0;
        if (mem_req_valid_o) begin
          if (st_cnt == 0) begin
            f_we = mem_we_o; f_addr = mem_addr_o; f_data = mem_data_wr_o;
          end else begin
            chk("stall_we", mem_we_o, f_we);
            chk("stall_addr", mem_addr_o, f_addr);
            chk("stall_data", mem_data_wr_o, f_data);
          end
          if (st_cnt >= stall_cfg) begin
            mem_req_ready_i = 1'b1;
            lg_we.push_back(mem_we_o);
            lg_addr.push_back(mem_addr_o);
            lg_data.push_back(mem_data_wr_o);
            if (mem_we_o) mem_store[mem_addr_o] = mem_data_wr_o;
            else          pend_addr = mem_addr_o;
            st_cnt = 0;
          end else begin
            mem_req_ready_i = 1'b0;
            st_cnt++;
          end
        end else begin
          mem_req_ready_i = 1'b0;
          st_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d, output logic [31:0] rd, output int cyc);
    @(negedge clk);
    valid_i = 1'b1; we_i = we; addr_i = a; be_i = be; data_wr_i = d;
    #1;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    rd = data_rd_o;
    @(posedge clk); #1;
    valid_i = 1'b0; we_i = 1'b0; be_i = '0;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input int exp_cyc);
    logic [31:0] rd; int cyc;
    do_req(1'b0, a, 4'h0, 32'h0, rd, cyc);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_cyc"}, cyc, exp_cyc);
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] rd; int cyc;
    do_req(1'b1, a, be, d, rd, cyc);
    chk({tag, "_rd0"}, rd, 32'h0);
    chk({tag, "_cyc"}, cyc, 0);
  endtask

  task automatic expect_req(input string tag, input logic we, input logic [31:0] a, input logic [127:0] d);
    chk({tag, "_present"}, lg_addr.size() != 0, 1'b1);
    if (lg_addr.size() != 0) begin
      chk({tag, "_we"}, lg_we.pop_front(), we);
      chk({tag, "_addr"}, lg_addr.pop_front(), a);
      if (we) chk({tag, "_wdata"}, lg_data.pop_front(), d);
      else    void'(lg_data.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_i = 1'b1; valid_i = 1'b0;
    @(negedge clk); @(negedge clk); rst_i = 1'b0;
  endtask

  initial begin
    int w;
    // Reset state
    @(negedge clk); @(negedge clk);
    valid_i = 1'b1; addr_i = 32'h100; #1;
    chk("rst_ready_busy", ready_o, 1'b0);
    valid_i = 1'b0; #1;
    chk("rst_ready_idle", ready_o, 1'b1);
    chk("rst_rd", data_rd_o, 32'h0);
    chk("rst_mreq", mem_req_valid_o, 1'b0);
    chk("rst_mwe", mem_we_o, 1'b0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    chk("rst_mdata", mem_data_wr_o, 128'h0);
    chk("rst_rsprdy", mem_rsp_ready_o, 1'b0);
    @(negedge clk); rst_i = 1'b0;

    // Cold load, reload hit, store merge
    ld("cold_0x100", 32'h100, 32'h11, 3);
    expect_req("cold_req", 1'b0, 32'h100, '0);
    ld("reload_0x100", 32'h100, 32'h11, 0);
    ld("load_0x104", 32'h104, 32'h22, 0);
    st("store_0x104", 32'h104, 4'b0011, 32'hAABB_CCDD);
    ld("merged_0x104", 32'h104, 32'h0000_CCDD, 0);
    chk("store_no_mem", lg_addr.size(), 0);

    // Reset while a refill is outstanding
    manual_mem = 1'b1;
    @(negedge clk);
    valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h300; mem_req_ready_i = 1'b1;
    w = 0;
    #1;
    while (!mem_rsp_ready_o && w < 20) begin @(negedge clk); #1; w++; end
    chk("reach_refill_wait", mem_rsp_ready_o, 1'b1);
    rst_i = 1'b1; mem_req_ready_i = 1'b0;
    @(negedge clk); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_data_line_i = {4{32'hBAD0_BAD0}};
    @(negedge clk); #1;
    mem_rsp_valid_i = 1'b0; mem_data_line_i = '0;
    chk("midrst_ready", ready_o, 1'b1);
    chk("midrst_mreq", mem_req_valid_o, 1'b0);
    chk("midrst_rsprdy", mem_rsp_ready_o, 1'b0);
    manual_mem = 1'b0;
    ld("after_rst_0x300", 32'h300, 32'hA000_0300, 3);
    expect_req("after_rst_req", 1'b0, 32'h300, '0);
    ld("lost_dirty_0x104", 32'h104, 32'h22, 3);
    expect_req("lost_dirty_req", 1'b0, 32'h100, '0);

    // Dirty eviction with stalled memory
    do_reset();
    ld("fill_0x000", 32'h000, 32'hA000_0000, 3);
    expect_req("fill0_req", 1'b0, 32'h000, '0);
    st("dirty_0x000", 32'h000, 4'hF, 32'hDEAD_BEEF);
    ld("fill_0x100", 32'h100, 32'h11, 3);
    expect_req("fill1_req", 1'b0, 32'h100, '0);
    st("dirty_0x10c", 32'h10C, 4'b1100, 32'h5566_7788);
    stall_cfg = 5;
    ld("evict_0x200", 32'h200, 32'hA000_0200, 14);
    stall_cfg = 0;
    expect_req("wb_0x000", 1'b1, 32'h000, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hDEAD_BEEF});
    expect_req("refill_0x200", 1'b0, 32'h200, '0);
    ld("rr_evict_way1", 32'h000, 32'hDEAD_BEEF, 4);
    expect_req("wb_0x100", 1'b1, 32'h100, {32'h5566_0044, 32'h33, 32'h22, 32'h11});
    expect_req("refill_0x000", 1'b0, 32'h000, '0);
    ld("clean_evict", 32'h10C, 32'h5566_0044, 3);
    expect_req("refill_0x100", 1'b0, 32'h100, '0);
    chk("clean_no_wb", lg_addr.size(), 0);

    // Zero byte-enable store still dirties the line
    st("be0_0x004", 32'h004, 4'h0, 32'hFFFF_FFFF);
    ld("be0_unchanged", 32'h004, 32'hA000_0001, 0);
    ld("be0_evict", 32'h300, 32'hA000_0300, 4);
    expect_req("be0_wb", 1'b1, 32'h000, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hDEAD_BEEF});
    expect_req("be0_refill", 1'b0, 32'h300, '0);
    chk("log_drained", lg_addr.size(), 0);

`ifdef DCACHE_PERF_CNT_EN
    do_reset();
    #1;
    chk("perf_rst_hit", perf_hit_o, 32'd0);
    ld("perf_a", 32'h000, 32'hDEAD_BEEF, 3);
    st("perf_b", 32'h000, 4'hF, 32'h1234_5678);
    ld("perf_c", 32'h100, 32'h11, 3);
    ld("perf_d", 32'h200, 32'hA000_0200, 4);
    @(negedge clk); #1;
    chk("perf_hit", perf_hit_o, 32'd4);
    chk("perf_miss", perf_miss_o, 32'd3);
    chk("perf_wb", perf_wb_o, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
